// File: rtl/hwag_pkg.sv
// Shared angle-generator types and constants for the coil scheduler.
// Angle counter counts down from HWAG_ANGLE_MAX to 0 each revolution.
package hwag_pkg;

  localparam int HWAG_ANGLE_W    = 16;
  localparam int HWAG_ANGLE_MAX  = 3839;
  localparam int TICKS_PER_TOOTH = 64;

  typedef logic [HWAG_ANGLE_W-1:0] angle_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SET,
    ON,
    DONE
  } ch_state_e;

endpackage

// File: rtl/angle_window_comp.sv
// Registered window comparator shared by all channels via the scan pipe.
// in_window: reached set but not yet reset; past_reset: reset reached.
module angle_window_comp #(
  parameter int ANGLE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ANGLE_W-1:0] angle,
  input  logic [ANGLE_W-1:0] set_a,
  input  logic [ANGLE_W-1:0] reset_a,
  output logic               in_window,
  output logic               past_reset
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_window  <= 1'b0;
      past_reset <= 1'b0;
    end else begin
      in_window  <= (angle <= set_a) && (angle > reset_a);
      past_reset <= (angle <= reset_a);
    end
  end

endmodule

// File: rtl/coil_scheduler.sv
// Multi-channel coil/injector scheduler on the down-counting main angle.
// One comparator is shared round-robin; shadow angles go live at wrap.
module coil_scheduler
  import hwag_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int ANGLE_W   = HWAG_ANGLE_W,
  parameter int ANGLE_MAX = HWAG_ANGLE_MAX,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               wrap,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [ANGLE_W-1:0] wr_set,
  input  logic [ANGLE_W-1:0] wr_reset,
  output logic               wr_ack,
  output logic               wr_err,
  output logic [N_CH-1:0]    coil_out,
  output logic [N_CH-1:0]    overrun,
  input  logic               clr_overrun
);

  localparam logic [ANGLE_W-1:0] MAX_A = ANGLE_W'(ANGLE_MAX);
  localparam logic [CH_W:0]      NCH_V = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0]    LAST  = CH_W'(N_CH-1);

  logic [ANGLE_W-1:0] sh_set  [N_CH];
  logic [ANGLE_W-1:0] sh_rst  [N_CH];
  logic [ANGLE_W-1:0] act_set [N_CH];
  logic [ANGLE_W-1:0] act_rst [N_CH];
  ch_state_e          st      [N_CH];

  logic               wr_ok;
  logic [N_CH-1:0]    en_next;

  logic [CH_W-1:0]    ptr;
  logic [CH_W-1:0]    s1_ch;
  logic [CH_W-1:0]    s2_ch;
  logic               s1_vld;
  logic               s2_vld;
  logic [ANGLE_W-1:0] s1_angle;
  logic [ANGLE_W-1:0] s1_set;
  logic [ANGLE_W-1:0] s1_rst;
  logic               in_win;
  logic               past_rst;

  always_comb begin
    wr_ok = ({1'b0, wr_ch} < NCH_V)
         && (wr_set <= MAX_A)
         && (wr_reset <= MAX_A);
  end

  // Enable test on the values the wrap is about to make active.
  always_comb begin
    en_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      en_next[i] = sh_set[i] > sh_rst[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        sh_set[i]  <= '0;
        sh_rst[i]  <= '0;
        act_set[i] <= '0;
        act_rst[i] <= '0;
      end
    end else begin
      wr_ack <= wr_en && wr_ok;
      wr_err <= wr_en && !wr_ok;
      if (wrap) begin
        for (int i = 0; i < N_CH; i++) begin
          act_set[i] <= sh_set[i];
          act_rst[i] <= sh_rst[i];
        end
      end
      if (wr_en && wr_ok) begin
        sh_set[wr_ch] <= wr_set;
        sh_rst[wr_ch] <= wr_reset;
      end
    end
  end

  // Scan entries loaded or in flight across a wrap see the old revolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      s1_ch    <= '0;
      s2_ch    <= '0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s1_angle <= '0;
      s1_set   <= '0;
      s1_rst   <= '0;
    end else begin
      ptr      <= (ptr == LAST) ? '0 : ptr + CH_W'(1);
      s1_ch    <= ptr;
      s1_angle <= angle;
      s1_set   <= act_set[ptr];
      s1_rst   <= act_rst[ptr];
      s1_vld   <= !wrap;
      s2_ch    <= s1_ch;
      s2_vld   <= s1_vld && !wrap;
    end
  end

  angle_window_comp #(
    .ANGLE_W   (ANGLE_W)
  ) u_comp (
    .clk       (clk),
    .rst       (rst),
    .angle     (s1_angle),
    .set_a     (s1_set),
    .reset_a   (s1_rst),
    .in_window (in_win),
    .past_reset(past_rst)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coil_out <= '0;
      overrun  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st[i] <= IDLE;
      end
    end else begin
      if (clr_overrun) begin
        overrun <= '0;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (!sync) begin
          st[i]       <= IDLE;
          coil_out[i] <= 1'b0;
        end else if (wrap) begin
          coil_out[i] <= 1'b0;
          if (st[i] == ON) begin
            overrun[i] <= 1'b1;
          end
          st[i] <= en_next[i] ? WAIT_SET : IDLE;
        end else if (s2_vld && (s2_ch == CH_W'(i))) begin
          unique case (1'b1)
            (st[i] == WAIT_SET) && past_rst: begin
              st[i] <= DONE;
            end
            (st[i] == WAIT_SET) && in_win: begin
              st[i]       <= ON;
              coil_out[i] <= 1'b1;
            end
            (st[i] == ON) && past_rst: begin
              st[i]       <= DONE;
              coil_out[i] <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_coil_scheduler.sv
// Scoreboard bench for coil_scheduler: revolution-level model vs DUT.
// Expected edges carry a cycle window; a monitor pops and checks them.
module tb_coil_scheduler;

  localparam int N_CH = 4;
  localparam int AW   = 16;
  localparam int AMAX = 3839;
  localparam int LAT  = N_CH + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            sync;
  logic [AW-1:0]   angle;
  logic            wrap;
  logic            wr_en;
  logic [1:0]      wr_ch;
  logic [AW-1:0]   wr_set;
  logic [AW-1:0]   wr_reset;
  logic            wr_ack;
  logic            wr_err;
  logic [N_CH-1:0] coil_out;
  logic [N_CH-1:0] overrun;
  logic            clr_overrun;

  always #5 clk = ~clk;

  coil_scheduler #(
    .N_CH       (N_CH),
    .ANGLE_W    (AW),
    .ANGLE_MAX  (AMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .angle      (angle),
    .wrap       (wrap),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_set     (wr_set),
    .wr_reset   (wr_reset),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .coil_out   (coil_out),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  typedef struct {
    int lvl;
    int t_min;
    int t_max;
  } ev_t;

  typedef struct {
    logic ok;
    int   t;
  } wx_t;

  ev_t eq [N_CH][$];
  wx_t wq [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;
  logic [N_CH-1:0] prev_coil;

  // Model: shadow/active windows and per-revolution phase
  // (0 off, 1 armed, 2 output on, 3 finished).
  int m_sh_s [N_CH];
  int m_sh_r [N_CH];
  int m_set  [N_CH];
  int m_rst  [N_CH];
  int m_ph   [N_CH];
  logic [N_CH-1:0] m_ovr;

  int   cur_angle;
  logic want_sync;
  logic p_wr;
  logic p_clr;
  int   p_ch;
  int   p_s;
  int   p_r;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    wx_t w;
    if (mon_en) begin
      for (int c = 0; c < N_CH; c++) begin
        if (coil_out[c] !== prev_coil[c]) begin
          total++;
          if (eq[c].size() == 0) begin
            bad++;
            $display("FAIL coil%0d unexpected edge to %0b at cyc %0d",
                     c, coil_out[c], cyc);
          end else begin
            e = eq[c].pop_front();
            if (e.lvl != int'(coil_out[c]) || cyc < e.t_min || cyc > e.t_max) begin
              bad++;
              $display("FAIL coil%0d edge got lvl=%0b cyc=%0d want lvl=%0d in [%0d,%0d]",
                       c, coil_out[c], cyc, e.lvl, e.t_min, e.t_max);
            end
          end
        end
      end
      prev_coil = coil_out;
      if (wr_ack || wr_err) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL wr_resp unexpected ack=%0b err=%0b cyc %0d", wr_ack, wr_err, cyc);
        end else begin
          w = wq.pop_front();
          if (wr_ack != w.ok || wr_err != !w.ok || cyc != w.t) begin
            bad++;
            $display("FAIL wr_resp got ack=%0b err=%0b cyc=%0d want ok=%0b cyc=%0d",
                     wr_ack, wr_err, cyc, w.ok, w.t);
          end
        end
      end
    end
  end

  task automatic push_ev(input int c, input int lvl, input int t0, input int t1);
    eq[c].push_back('{lvl, t0, t1});
  endtask

  // One clock: apply inputs and advance the model by the same rules.
  task automatic drive(input logic w, input logic nt);
    int  k;
    logic ok;
    @(posedge clk);
    #1;
    k           = cyc;
    angle       = AW'(cur_angle);
    wrap        = w;
    sync        = want_sync;
    wr_en       = p_wr;
    wr_ch       = 2'(p_ch);
    wr_set      = AW'(p_s);
    wr_reset    = AW'(p_r);
    clr_overrun = p_clr;
    if (p_clr) m_ovr = '0;
    if (!want_sync) begin
      for (int c = 0; c < N_CH; c++) begin
        if (m_ph[c] == 2) push_ev(c, 0, k + 1, k + 1);
        m_ph[c] = 0;
      end
    end else if (w) begin
      for (int c = 0; c < N_CH; c++) begin
        if (m_ph[c] == 2) begin
          push_ev(c, 0, k + 1, k + 1);
          m_ovr[c] = 1'b1;
        end
        m_ph[c] = (m_sh_s[c] > m_sh_r[c]) ? 1 : 0;
      end
    end else if (nt) begin
      for (int c = 0; c < N_CH; c++) begin
        if (m_ph[c] == 1 && cur_angle <= m_set[c]) begin
          if (cur_angle > m_rst[c]) begin
            push_ev(c, 1, k + 3, k + LAT);
            m_ph[c] = 2;
          end else begin
            m_ph[c] = 3;
          end
        end else if (m_ph[c] == 2 && cur_angle <= m_rst[c]) begin
          push_ev(c, 0, k + 3, k + LAT);
          m_ph[c] = 3;
        end
      end
    end
    if (w) begin
      for (int c = 0; c < N_CH; c++) begin
        m_set[c] = m_sh_s[c];
        m_rst[c] = m_sh_r[c];
      end
    end
    if (p_wr) begin
      ok = (p_ch < N_CH) && (p_s <= AMAX) && (p_r <= AMAX);
      wq.push_back('{ok, k + 1});
      if (ok) begin
        m_sh_s[p_ch] = p_s;
        m_sh_r[p_ch] = p_r;
      end
    end
    p_wr  = 1'b0;
    p_clr = 1'b0;
  endtask

  task automatic wr1(input int ch, input int s, input int r);
    p_wr = 1'b1;
    p_ch = ch;
    p_s  = s;
    p_r  = r;
    drive(1'b0, 1'b0);
  endtask

  // One revolution: wrap, then a randomized down-sweep of the angle.
  task automatic rev(input int stop_at, input int drop_at, input int on_at,
                     input int wr_at, input int wch, input int ws, input int wrr,
                     input bit fine);
    int st;
    int hold;
    int nxt;
    bit stopping;
    bit dropped;
    bit wdone;
    stopping  = 1'b0;
    dropped   = 1'b0;
    wdone     = 1'b0;
    cur_angle = AMAX;
    drive(1'b1, 1'b0);
    while (cur_angle > 0 && !stopping) begin
      if (cur_angle < 600) st = fine ? 1 : int'($urandom_range(1, 3));
      else                 st = int'($urandom_range(4, 16));
      hold = fine ? 8 : int'($urandom_range(4, 8));
      nxt  = (cur_angle > st) ? cur_angle - st : 0;
      if (stop_at >= 0 && nxt <= stop_at) begin
        nxt      = stop_at;
        stopping = 1'b1;
      end
      if (drop_at >= 0 && !dropped && nxt <= drop_at) begin
        nxt     = drop_at;
        dropped = 1'b1;
        repeat (4) drive(1'b0, 1'b0);
        want_sync = 1'b0;
      end
      if (on_at >= 0 && !want_sync && nxt <= on_at) want_sync = 1'b1;
      if (wr_at >= 0 && !wdone && nxt <= wr_at) begin
        wdone = 1'b1;
        p_wr  = 1'b1;
        p_ch  = wch;
        p_s   = ws;
        p_r   = wrr;
      end
      cur_angle = nxt;
      drive(1'b0, 1'b1);
      repeat (hold - 1) drive(1'b0, 1'b0);
    end
    repeat (stopping ? 10 : 8) drive(1'b0, 1'b0);
  endtask

  task automatic chk_state(input string nm);
    logic [N_CH-1:0] on_m;
    for (int c = 0; c < N_CH; c++) on_m[c] = (m_ph[c] == 2);
    @(negedge clk);
    chk({nm, "_ovr"}, int'(overrun), int'(m_ovr));
    chk({nm, "_coil"}, int'(coil_out), int'(on_m));
  endtask

  initial begin
    rst         = 1'b0;
    sync        = 1'b0;
    wrap        = 1'b0;
    wr_en       = 1'b0;
    clr_overrun = 1'b0;
    angle       = '0;
    wr_ch       = '0;
    wr_set      = '0;
    wr_reset    = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_sh_s[c] = 0;
      m_sh_r[c] = 0;
      m_set[c]  = 0;
      m_rst[c]  = 0;
      m_ph[c]   = 0;
    end
    m_ovr     = '0;
    cur_angle = 0;
    want_sync = 1'b1;
    p_wr      = 1'b0;
    p_clr     = 1'b0;
    p_ch      = 0;
    p_s       = 0;
    p_r       = 0;

    repeat (3) @(negedge clk);
    chk("rst_coil", int'(coil_out), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_ack", int'(wr_ack), 0);
    chk("rst_err", int'(wr_err), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    prev_coil = coil_out;
    mon_en    = 1'b1;

    // Basic window on ch0 with fine sweep.
    wr1(0, 200, 100);
    rev(-1, -1, -1, -1, 0, 0, 0, 1'b1);
    chk_state("t1");

    // ch1 written mid-revolution: live only after the next wrap.
    rev(-1, -1, -1, 2000, 1, 3800, 3700, 1'b0);
    chk_state("t2a");
    wr1(2, 50, 10);
    rev(-1, 30, -1, -1, 0, 0, 0, 1'b0);
    chk_state("t3a");
    rev(-1, -1, 2000, -1, 0, 0, 0, 1'b0);
    chk_state("t3b");

    // Lost tooth: wrap arrives while ch2/ch3 are on.
    wr1(3, 20, 5);
    rev(12, -1, -1, -1, 0, 0, 0, 1'b0);
    rev(12, -1, -1, -1, 0, 0, 0, 1'b0);
    chk_state("t4a");
    p_clr = 1'b1;
    rev(-1, -1, -1, -1, 0, 0, 0, 1'b0);
    chk_state("t4b");
    p_clr = 1'b1;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk_state("t4c");

    // Rejected writes leave the shadow; set==reset disables.
    wr1(0, 100, 100);
    wr1(1, 4000, 3900);
    wr1(2, 300, 4000);
    rev(-1, -1, -1, -1, 0, 0, 0, 1'b0);
    chk_state("t5");

    // Identical windows, then a write coincident with wrap.
    for (int c = 0; c < N_CH; c++) wr1(c, 500, 400);
    rev(-1, -1, -1, -1, 0, 0, 0, 1'b0);
    p_wr = 1'b1;
    p_ch = 0;
    p_s  = 1000;
    p_r  = 900;
    rev(-1, -1, -1, -1, 0, 0, 0, 1'b0);
    chk_state("t6a");
    rev(-1, -1, -1, -1, 0, 0, 0, 1'b0);
    chk_state("t6b");

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 2; j++) begin
        int s;
        int q;
        s = ($urandom_range(0, 7) == 0) ? 3840 + int'($urandom_range(0, 200))
                                        : int'($urandom_range(0, 3700));
        q = ($urandom_range(0, 7) == 0) ? 3900 : int'($urandom_range(0, 3700));
        wr1(int'($urandom_range(0, N_CH - 1)), s, q);
      end
      rev(-1, -1, -1, -1, 0, 0, 0, 1'b0);
      chk_state("rnd");
    end

    repeat (10) drive(1'b0, 1'b0);
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) begin
      total++;
      if (eq[c].size() != 0) begin
        bad++;
        $display("FAIL coil%0d missing %0d edge(s), next lvl=%0d by cyc %0d",
                 c, eq[c].size(), eq[c][0].lvl, eq[c][0].t_max);
      end
    end
    total++;
    if (wq.size() != 0) begin
      bad++;
      $display("FAIL wr_resp missing %0d response(s)", wq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
